// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbitrated mux with valid/ready channels
//
// Purpose: CHANNELS producers share one consumer through a single registered
// output stage (1-cycle latency, 1 beat/cycle). The grant is chosen round-robin
// starting at ptr; the accepted beat is registered with its channel index.
//
// Optional feature macro: RR_MUX_ARBITER_PACKET_LOCK_EN
//   When defined, in_last/out_last are added and a channel keeps the grant
//   from its first non-last beat until its last beat is accepted.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-low reset
//   in_data    in   CHANNELS*N   channel i at [i*N +: N]
//   in_valid   in   CHANNELS     channel i presents a beat
//   in_ready   out  CHANNELS     channel i beat accepted this cycle
//   in_last    in   CHANNELS     (lock build only) final beat of a packet
//   out_data   out  N            registered data
//   out_select out  SEL_W        channel that produced out_data
//   out_valid  out  1            output stage holds a beat
//   out_last   out  1            (lock build only) registered in_last
//   out_ready  in   1            consumer accepts the beat
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  input  logic [CHANNELS-1:0]   in_last,
  output logic                  out_last,
`endif
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_select,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             have_grant;
  logic             load_ok;
  logic             accept;

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;
`endif

  assign load_ok = (state == EMPTY) | out_ready;
  // rst gates the handshake so nothing is reported accepted while in reset.
  assign accept  = have_grant & load_ok & rst;

  // Round-robin search; the index wraps explicitly so non-power-of-two
  // channel counts never produce an out-of-range grant.
  always_comb begin
    int idx;
    grant      = '0;
    have_grant = 1'b0;
    idx        = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!have_grant && in_valid[idx]) begin
        grant      = SEL_W'(idx);
        have_grant = 1'b1;
      end
    end
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    // A locked packet owns the output even while its producer idles.
    if (lock) begin
      grant      = lock_ch;
      have_grant = in_valid[lock_ch];
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (accept) in_ready = CHANNELS'(1) << grant;
  end

  // Output stage FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  // Output stage FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Output stage FSM: outputs
  always_comb begin
    out_valid = (state == FULL);
  end

  // Datapath, pointer and packet lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data   <= '0;
      out_select <= '0;
      ptr        <= '0;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      out_last   <= 1'b0;
      lock       <= 1'b0;
      lock_ch    <= '0;
`endif
    end else if (accept) begin
      out_data   <= in_data[int'(grant)*N +: N];
      out_select <= grant;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      out_last   <= in_last[grant];
      if (in_last[grant]) begin
        lock <= 1'b0;
        ptr  <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end else begin
        lock    <= 1'b1;
        lock_ch <= grant;
      end
`else
      ptr        <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter (4 and 3 channels)
module tb_rr_mux_arbiter;

  typedef struct {
    int sel;
    int data;
  } beat_t;

  logic        clk;
  logic        rst;

  logic [15:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [3:0]  a_in_last;
  logic        a_out_last;
  logic [3:0]  a_out_data;
  logic [1:0]  a_out_select;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [11:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [2:0]  b_in_last;
  logic        b_out_last;
  logic [3:0]  b_out_data;
  logic [1:0]  b_out_select;
  logic        b_out_valid;
  logic        b_out_ready;

  beat_t qa[$];
  beat_t qb[$];
  int    errors = 0;
  int    checks = 0;

  rr_mux_arbiter #(.N(4), .CHANNELS(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    .in_last(a_in_last), .out_last(a_out_last),
`endif
    .out_data(a_out_data), .out_select(a_out_select),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  rr_mux_arbiter #(.N(4), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    .in_last(b_in_last), .out_last(b_out_last),
`endif
    .out_data(b_out_data), .out_select(b_out_select),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_a(input int sel, input int data);
    beat_t b;
    b.sel = sel;
    b.data = data;
    qa.push_back(b);
  endtask

  task automatic push_b(input int sel, input int data);
    beat_t b;
    b.sel = sel;
    b.data = data;
    qb.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    a_in_valid  = 4'b0000;
    a_out_ready = 1'b1;
    step();
    step();
  endtask

  // Monitors: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        check("a_unexpected_beat_sel", int'(a_out_select), -1);
      end else begin
        beat_t e;
        e = qa.pop_front();
        check("a_beat_select", int'(a_out_select), e.sel);
        check("a_beat_data", int'(a_out_data), e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        check("b_unexpected_beat_sel", int'(b_out_select), -1);
      end else begin
        beat_t e;
        e = qb.pop_front();
        check("b_beat_select", int'(b_out_select), e.sel);
        check("b_beat_data", int'(b_out_data), e.data);
      end
    end
  end

  initial begin
    rst         = 1'b0;
    a_in_valid  = 4'b1111;
    a_in_data   = {4'd11, 4'd10, 4'd9, 4'd8};
    a_in_last   = 4'b1111;
    a_out_ready = 1'b1;
    b_in_valid  = 3'b000;
    b_in_data   = {4'd3, 4'd2, 4'd1};
    b_in_last   = 3'b111;
    b_out_ready = 1'b1;

    // Reset state with all channels requesting
    #2;
    check("reset_out_valid", int'(a_out_valid), 0);
    check("reset_out_data", int'(a_out_data), 0);
    check("reset_out_select", int'(a_out_select), 0);
    check("reset_in_ready", int'(a_in_ready), 0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("first_grant_ch0", int'(a_in_ready), 4'b0001);

    // All four valid, one beat per cycle in round-robin order
    push_a(0, 8); push_a(1, 9); push_a(2, 10); push_a(3, 11); push_a(0, 8);
    for (int i = 0; i < 5; i++) begin
      step();
      check("throughput_out_valid", int'(a_out_valid), 1);
    end
    drain_a();

    // Backpressure: ptr=1, ch2 beat 5 held while consumer stalls
    a_in_valid  = 4'b0100;
    a_in_data   = {4'd11, 4'd5, 4'd9, 4'd8};
    a_out_ready = 1'b0;
    push_a(2, 5);
    step();
    a_in_valid = 4'b0101;
    a_in_data  = {4'd11, 4'd6, 4'd9, 4'd8};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_out_data", int'(a_out_data), 5);
      check("stall_out_select", int'(a_out_select), 2);
      check("stall_in_ready", int'(a_in_ready), 0);
      step();
    end
    a_out_ready = 1'b1;
    push_a(0, 8);
    #1;
    check("resume_rr_grant", int'(a_in_ready), 4'b0001);
    step();
    a_in_valid = 4'b0100;
    push_a(2, 6);
    step();
    drain_a();

    // Wrap: ptr=3, only ch3 valid, then ch1 alone, then ptr must be 2
    a_in_valid = 4'b1000;
    a_in_data  = {4'hF, 4'd10, 4'd9, 4'd8};
    push_a(3, 15);
    step();
    a_in_valid = 4'b0010;
    a_in_data  = {4'd11, 4'd10, 4'd9, 4'd8};
    push_a(1, 9);
    step();
    a_in_valid = 4'b1111;
    #1;
    check("ptr_after_wrap", int'(a_in_ready), 4'b0100);
    push_a(2, 10);
    step();
    drain_a();

    // Reset while the output stage is full: the held beat is dropped
    a_in_valid  = 4'b0001;
    a_out_ready = 1'b0;
    step();
    check("pre_reset_full", int'(a_out_valid), 1);
    a_in_valid = 4'b1111;
    #2;
    rst = 1'b0;
    #1;
    check("midreset_out_valid", int'(a_out_valid), 0);
    check("midreset_out_select", int'(a_out_select), 0);
    check("midreset_out_data", int'(a_out_data), 0);
    check("midreset_in_ready", int'(a_in_ready), 0);
    step();
    rst = 1'b1;
    #1;
    check("post_reset_ch0", int'(a_in_ready), 4'b0001);
    a_out_ready = 1'b1;
    push_a(0, 8);
    step();
    drain_a();

    // Three channels: indices 0,1,2 only
    b_in_valid = 3'b111;
    push_b(0, 1); push_b(1, 2); push_b(2, 3); push_b(0, 1); push_b(1, 2);
    for (int i = 0; i < 5; i++) step();
    b_in_valid = 3'b000;
    step();
    step();

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    // Packet lock: ptr=1, ch1 sends last=0,0,1 while ch0/ch2 wait
    a_in_valid = 4'b0111;
    a_in_data  = {4'd11, 4'd10, 4'd1, 4'd8};
    a_in_last  = 4'b1101;
    push_a(1, 1);
    #1;
    check("lock_first_grant", int'(a_in_ready), 4'b0010);
    step();
    check("lock_out_last0", int'(a_out_last), 0);
    a_in_data = {4'd11, 4'd10, 4'd2, 4'd8};
    push_a(1, 2);
    step();
    a_in_valid = 4'b0101;
    #1;
    check("lock_gap_stall", int'(a_in_ready), 4'b0000);
    step();
    a_in_valid = 4'b0111;
    a_in_data  = {4'd11, 4'd10, 4'd3, 4'd8};
    a_in_last  = 4'b1111;
    push_a(1, 3);
    step();
    check("lock_out_last1", int'(a_out_last), 1);
    push_a(2, 10);
    step();
    drain_a();
`endif

    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
